// File: rtl/bmp_crop_engine_if.sv
// Bus bundle for bmp_crop_engine: run control, source read port and destination write port.
// The engine takes the slave side; the controller/memory environment takes the master side.
interface bmp_crop_engine_if #(
  parameter int ADDR_W = 32
);
  logic              start;
  logic [10:0]       x_min;
  logic [10:0]       x_max;
  logic [10:0]       y_min;
  logic [10:0]       y_max;
  logic              flip_v;
  logic              mirror_h;
  logic [ADDR_W-1:0] dst_base;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wren;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] bytes_out;

  modport slave (
    input  start, x_min, x_max, y_min, y_max, flip_v, mirror_h, dst_base, rd_data,
    output rd_addr, wr_addr, wr_data, wren, busy, done, err, bytes_out
  );

  modport master (
    output start, x_min, x_max, y_min, y_max, flip_v, mirror_h, dst_base, rd_data,
    input  rd_addr, wr_addr, wr_data, wren, busy, done, err, bytes_out
  );
endinterface

// File: rtl/bmp_crop_engine.sv
// Copies a rectangular window of a BMP pixel array into a packed destination whose rows
// are zero-padded to 4 bytes, with optional vertical flip and horizontal mirror.
module bmp_crop_engine #(
  parameter int WIDTH     = 100,
  parameter int HEIGHT    = 100,
  parameter int BPP       = 3,
  parameter int ADDR_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int HDR_BYTES = 54
) (
  input  logic               clk,
  input  logic               rst_n,
  bmp_crop_engine_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_FETCH,
    S_WRITE,
    S_PAD,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] SRC_STRIDE = ADDR_W'(((WIDTH * BPP + 3) >> 2) << 2);
  localparam logic [ADDR_W-1:0] BPP_A      = ADDR_W'(BPP);
  localparam logic [ADDR_W-1:0] ROW_LAST   = ADDR_W'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] HDR_A      = ADDR_W'(HDR_BYTES);
  localparam logic [31:0]       WIDTH_U    = 32'(WIDTH);
  localparam logic [31:0]       HEIGHT_U   = 32'(HEIGHT);
  localparam logic [1:0]        C_LAST     = 2'(BPP - 1);
  localparam logic [1:0]        LAT_LAST   = 2'(RD_LAT - 1);
  localparam logic [1:0]        BPP_2      = 2'(BPP);

  state_t r_state;
  state_t w_state_nxt;

  logic [10:0]       r_x_min;
  logic [10:0]       r_x_max;
  logic [10:0]       r_y_min;
  logic [10:0]       r_y_max;
  logic              r_flip;
  logic              r_mirror;
  logic [10:0]       r_row;
  logic [10:0]       r_col;
  logic [1:0]        r_c;
  logic [1:0]        r_lat_cnt;
  logic [1:0]        r_pad_len;
  logic [1:0]        r_pad_cnt;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_bytes;
  logic              r_err;

  logic              w_bad;
  logic [10:0]       w_col_first;
  logic [10:0]       w_col_end;
  logic [10:0]       w_win_w;
  logic [1:0]        w_row_lo;
  logic [1:0]        w_pad_len;
  logic              w_last_c;
  logic              w_last_col;
  logic              w_last_row;
  logic              w_lat_done;
  logic              w_accept;
  logic              w_wren;
  logic [7:0]        w_wr_data;
  logic [10:0]       w_row_nxt;
  logic [10:0]       w_col_nxt;
  logic [1:0]        w_c_nxt;
  logic [ADDR_W-1:0] w_rd_row;
  logic [ADDR_W-1:0] w_rd_addr_nxt;
  logic              w_load;

  assign w_bad = (r_x_min > r_x_max) || (r_y_min > r_y_max) ||
                 ({21'd0, r_x_max} >= WIDTH_U) || ({21'd0, r_y_max} >= HEIGHT_U);

  assign w_col_first = r_mirror ? r_x_max : r_x_min;
  assign w_col_end   = r_mirror ? r_x_min : r_x_max;

  // Only the row length mod 4 matters for padding, so a 2-bit product is enough.
  assign w_win_w   = r_x_max - r_x_min + 11'd1;
  assign w_row_lo  = w_win_w[1:0] * BPP_2;
  assign w_pad_len = 2'd0 - w_row_lo;

  assign w_last_c   = (r_c == C_LAST);
  assign w_last_col = (r_col == w_col_end);
  assign w_last_row = (r_row == r_y_max);
  assign w_lat_done = (r_lat_cnt == LAT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_wren      = 1'b0;
    w_wr_data   = 8'd0;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_c_nxt     = r_c;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        w_row_nxt   = r_y_min;
        w_col_nxt   = w_col_first;
        w_c_nxt     = 2'd0;
        w_state_nxt = w_bad ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        if (w_lat_done) begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        w_wren    = 1'b1;
        w_wr_data = bus.rd_data;
        if (!w_last_c) begin
          w_c_nxt     = r_c + 2'd1;
          w_state_nxt = S_FETCH;
        end else if (!w_last_col) begin
          w_col_nxt   = r_mirror ? (r_col - 11'd1) : (r_col + 11'd1);
          w_c_nxt     = 2'd0;
          w_state_nxt = S_FETCH;
        end else if (r_pad_len != 2'd0) begin
          w_state_nxt = S_PAD;
        end else if (w_last_row) begin
          w_state_nxt = S_DONE;
        end else begin
          w_row_nxt   = r_row + 11'd1;
          w_col_nxt   = w_col_first;
          w_c_nxt     = 2'd0;
          w_state_nxt = S_FETCH;
        end
      end
      S_PAD: begin
        w_wren = 1'b1;
        if (r_pad_cnt == 2'd1) begin
          if (w_last_row) begin
            w_state_nxt = S_DONE;
          end else begin
            w_row_nxt   = r_row + 11'd1;
            w_col_nxt   = w_col_first;
            w_c_nxt     = 2'd0;
            w_state_nxt = S_FETCH;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Source address of the next byte to fetch; loaded once per byte and held through FETCH.
  assign w_rd_row      = r_flip ? (ROW_LAST - ADDR_W'(w_row_nxt)) : ADDR_W'(w_row_nxt);
  assign w_rd_addr_nxt = w_rd_row * SRC_STRIDE + ADDR_W'(w_col_nxt) * BPP_A + ADDR_W'(w_c_nxt);
  assign w_load        = (w_state_nxt == S_FETCH) && (r_state != S_FETCH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x_min   <= 11'd0;
      r_x_max   <= 11'd0;
      r_y_min   <= 11'd0;
      r_y_max   <= 11'd0;
      r_flip    <= 1'b0;
      r_mirror  <= 1'b0;
      r_row     <= 11'd0;
      r_col     <= 11'd0;
      r_c       <= 2'd0;
      r_lat_cnt <= 2'd0;
      r_pad_len <= 2'd0;
      r_pad_cnt <= 2'd0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_bytes   <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_x_min   <= bus.x_min;
        r_x_max   <= bus.x_max;
        r_y_min   <= bus.y_min;
        r_y_max   <= bus.y_max;
        r_flip    <= bus.flip_v;
        r_mirror  <= bus.mirror_h;
        r_wr_addr <= (bus.dst_base == '0) ? HDR_A : bus.dst_base;
        r_bytes   <= '0;
        r_err     <= 1'b0;
      end
      if (r_state == S_CHECK) begin
        r_err     <= w_bad;
        r_pad_len <= w_pad_len;
      end
      if (w_load) begin
        r_row     <= w_row_nxt;
        r_col     <= w_col_nxt;
        r_c       <= w_c_nxt;
        r_rd_addr <= w_rd_addr_nxt;
      end
      if (r_state == S_FETCH) begin
        r_lat_cnt <= w_lat_done ? 2'd0 : (r_lat_cnt + 2'd1);
      end
      if (w_wren) begin
        r_wr_addr <= r_wr_addr + 1'b1;
        r_bytes   <= r_bytes + 1'b1;
      end
      if ((r_state == S_WRITE) && (w_state_nxt == S_PAD)) begin
        r_pad_cnt <= r_pad_len;
      end else if (r_state == S_PAD) begin
        r_pad_cnt <= r_pad_cnt - 2'd1;
      end
    end
  end

  assign bus.rd_addr   = r_rd_addr;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = w_wr_data;
  assign bus.wren      = w_wren;
  assign bus.busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.err       = r_err;
  assign bus.bytes_out = r_bytes;

endmodule

// File: tb/tb_bmp_crop_engine.sv
// Self-checking bench for bmp_crop_engine on a small 5x4, 3-byte-per-pixel image with a
// 3-cycle read latency, compared against a window-walk reference model.
module tb_bmp_crop_engine;

  localparam int IMG_W  = 5;
  localparam int IMG_H  = 4;
  localparam int BPP    = 3;
  localparam int RD_LAT = 3;
  localparam int HDR    = 54;
  localparam int STRIDE = ((IMG_W * BPP + 3) / 4) * 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   startCyc;

  logic [7:0]  srcMem [64];
  logic [7:0]  rdPipe [RD_LAT];
  logic [39:0] wrQ[$];
  int          wrCyc[$];

  bmp_crop_engine_if #(.ADDR_W(32)) bus ();

  bmp_crop_engine #(
    .WIDTH(IMG_W), .HEIGHT(IMG_H), .BPP(BPP), .ADDR_W(32), .RD_LAT(RD_LAT), .HDR_BYTES(HDR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Source RAM with RD_LAT cycles from address to data.
  always @(posedge clk) begin
    rdPipe[0] <= srcMem[bus.rd_addr[5:0]];
    for (int i = 1; i < RD_LAT; i++) rdPipe[i] <= rdPipe[i-1];
  end
  assign bus.rd_data = rdPipe[RD_LAT-1];

  always @(negedge clk) begin
    if (bus.wren === 1'b1) begin
      wrQ.push_back({bus.wr_addr, bus.wr_data});
      wrCyc.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int xmin, input int xmax, input int ymin, input int ymax,
                               input bit flip, input bit mirror, input logic [31:0] base);
    @(negedge clk);
    wrQ.delete();
    wrCyc.delete();
    bus.x_min    = 11'(xmin);
    bus.x_max    = 11'(xmax);
    bus.y_min    = 11'(ymin);
    bus.y_max    = 11'(ymax);
    bus.flip_v   = flip;
    bus.mirror_h = mirror;
    bus.dst_base = base;
    bus.start    = 1'b1;
    startCyc     = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic runCase(input string tag, input int xmin, input int xmax, input int ymin,
                         input int ymax, input bit flip, input bit mirror,
                         input logic [31:0] base, input bit glitch);
    logic [39:0] expQ[$];
    logic [31:0] b;
    bit bad;
    int w, h, rb, pad, lat, r, x, n;
    bad = (xmin > xmax) || (ymin > ymax) || (xmax >= IMG_W) || (ymax >= IMG_H);
    b   = (base == 0) ? 32'(HDR) : base;
    lat = 2;
    if (!bad) begin
      w   = xmax - xmin + 1;
      h   = ymax - ymin + 1;
      rb  = w * BPP;
      pad = (4 - rb % 4) % 4;
      for (int y = ymin; y <= ymax; y++) begin
        r = flip ? (IMG_H - 1 - y) : y;
        for (int i = 0; i < w; i++) begin
          x = mirror ? (xmax - i) : (xmin + i);
          for (int c = 0; c < BPP; c++)
            expQ.push_back({b + 32'(expQ.size()), srcMem[r * STRIDE + x * BPP + c]});
        end
        for (int p = 0; p < pad; p++) expQ.push_back({b + 32'(expQ.size()), 8'h00});
      end
      lat = 2 + h * (rb * (RD_LAT + 1) + pad);
    end
    applyStimulus(xmin, xmax, ymin, ymax, flip, mirror, base);
    if (glitch) begin
      bus.x_min  = 11'd0;
      bus.x_max  = 11'd0;
      bus.y_min  = 11'd0;
      bus.y_max  = 11'd0;
      bus.flip_v = ~flip;
    end
    n = 0;
    while (bus.done !== 1'b1 && n < 2000) begin
      bus.start = glitch && (n == 10);
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    checkOutput({tag, " done"}, 64'(bus.done), 64'd1);
    checkOutput({tag, " latency"}, 64'(cyc - startCyc), 64'(lat));
    checkOutput({tag, " err"}, 64'(bus.err), 64'(bad));
    checkOutput({tag, " busy"}, 64'(bus.busy), 64'd0);
    checkOutput({tag, " bytes_out"}, 64'(bus.bytes_out), 64'(expQ.size()));
    checkOutput({tag, " write count"}, 64'(wrQ.size()), 64'(expQ.size()));
    for (int i = 0; i < expQ.size(); i++)
      checkOutput({tag, " write"}, (i < wrQ.size()) ? 64'(wrQ[i]) : 64'hDEAD, 64'(expQ[i]));
    if (!bad && wrCyc.size() >= 2)
      checkOutput({tag, " wren spacing"}, 64'(wrCyc[1] - wrCyc[0]), 64'(RD_LAT + 1));
  endtask

  initial begin
    int n, xmin, xmax, ymin, ymax;
    for (int i = 0; i < 64; i++) srcMem[i] = 8'($urandom);
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.x_min    = '0;
    bus.x_max    = '0;
    bus.y_min    = '0;
    bus.y_max    = '0;
    bus.flip_v   = 1'b0;
    bus.mirror_h = 1'b0;
    bus.dst_base = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 64'(bus.busy), 64'd0);
    checkOutput("reset done", 64'(bus.done), 64'd0);
    checkOutput("reset err", 64'(bus.err), 64'd0);
    checkOutput("reset wren", 64'(bus.wren), 64'd0);
    checkOutput("reset wr_data", 64'(bus.wr_data), 64'd0);
    checkOutput("reset rd_addr", 64'(bus.rd_addr), 64'd0);
    checkOutput("reset wr_addr", 64'(bus.wr_addr), 64'd0);
    checkOutput("reset bytes_out", 64'(bus.bytes_out), 64'd0);
    rst_n = 1'b1;

    $display("[TB] directed windows");
    runCase("row4", 0, 3, 0, 0, 1'b0, 1'b0, 32'd0, 1'b0);
    runCase("single", 1, 1, 1, 1, 1'b0, 1'b0, 32'd0, 1'b0);
    runCase("mirror flip", 2, 3, 0, 0, 1'b1, 1'b1, 32'd0, 1'b0);
    runCase("full", 0, 4, 0, 3, 1'b1, 1'b0, 32'd300, 1'b0);
    runCase("xmax=W", 0, 5, 0, 0, 1'b0, 1'b0, 32'd0, 1'b0);
    runCase("xmin>xmax", 3, 2, 0, 1, 1'b0, 1'b0, 32'd0, 1'b0);
    runCase("ymax=H", 0, 1, 2, 4, 1'b0, 1'b0, 32'd0, 1'b0);
    runCase("glitch start", 1, 3, 1, 2, 1'b0, 1'b1, 32'd128, 1'b1);

    $display("[TB] random windows");
    for (int t = 0; t < 8; t++) begin
      xmin = $urandom_range(0, IMG_W - 1);
      xmax = $urandom_range(xmin, IMG_W - 1);
      ymin = $urandom_range(0, IMG_H - 1);
      ymax = $urandom_range(ymin, IMG_H - 1);
      runCase("random", xmin, xmax, ymin, ymax, 1'($urandom), 1'($urandom),
              ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(100, 1000)), 1'b0);
    end

    $display("[TB] reset mid-run");
    applyStimulus(0, 4, 0, 3, 1'b0, 1'b0, 32'd0);
    n = 0;
    while (wrQ.size() < 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midrun writes seen", 64'(wrQ.size() >= 5), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrun reset wren", 64'(bus.wren), 64'd0);
    checkOutput("midrun reset busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    checkOutput("midrun reset bytes_out", 64'(bus.bytes_out), 64'd0);
    checkOutput("midrun reset wren hold", 64'(bus.wren), 64'd0);
    rst_n = 1'b1;
    runCase("after reset", 1, 4, 0, 2, 1'b1, 1'b0, 32'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
